// File: rtl/router_pkg.sv
// Shared constants and helpers for the N-channel VOQ router.
// Statistics counters exist only when ROUTER_STATS_EN is defined.
package router_pkg;

    localparam int unsigned DEF_N_CH       = 32'd4;
    localparam int unsigned DEF_DATA_W     = 32'd8;
    localparam int unsigned DEF_FIFO_DEPTH = 32'd4;
    localparam int unsigned DEF_CNT_W      = 32'd16;

    function automatic int unsigned addr_w(input int unsigned n_ch);
        return (n_ch < 32'd2) ? 32'd1 : $clog2(n_ch);
    endfunction

    function automatic int unsigned pkt_w(input int unsigned n_ch, input int unsigned data_w);
        return addr_w(n_ch) + data_w;
    endfunction

    // Saturating increment of a w-bit value carried in a 64-bit container.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 32'd64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (v >= max_v) begin
            return max_v;
        end else begin
            return v + 64'd1;
        end
    endfunction

endpackage

// File: rtl/router_chan_fifo.sv
// Single-channel FIFO with explicit pointer wrap and occupancy counter.
// Head payload reads as zero while the FIFO is empty.
module router_chan_fifo #(
    parameter int unsigned DATA_W     = 32'd8,
    parameter int unsigned FIFO_DEPTH = 32'd4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 32'd1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  cnt_q, cnt_d;
    logic              push_s, pop_s;

    assign full_o  = (cnt_q == OCC_W'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 32'd1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 32'd1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (empty_o) begin
            head_o = '0;
        end else begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/router_nch_voq.sv
// 1-to-N packet router with one output queue per channel; out-of-range addresses are dropped.
// Optional statistics ports are enabled with ROUTER_STATS_EN.
module router_nch_voq
    import router_pkg::*;
#(
    parameter  int unsigned N_CH       = DEF_N_CH,
    parameter  int unsigned DATA_W     = DEF_DATA_W,
    parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
`ifdef ROUTER_STATS_EN
    parameter  int unsigned CNT_W      = DEF_CNT_W,
`endif
    localparam int unsigned ADDR_W     = addr_w(N_CH),
    localparam int unsigned PKT_W      = pkt_w(N_CH, DATA_W)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    input  logic [PKT_W-1:0]            data_i,
    output logic                        ready_o,
    output logic                        drop_o,
    output logic [N_CH-1:0]             valid_o,
    output logic [N_CH-1:0][DATA_W-1:0] data_o,
`ifdef ROUTER_STATS_EN
    output logic [N_CH-1:0][CNT_W-1:0]  pkt_cnt_o,
    output logic [CNT_W-1:0]            drop_cnt_o,
`endif
    input  logic [N_CH-1:0]             ready_i
);

    localparam int unsigned N_SLOT = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] N_CH_L = (ADDR_W + 1)'(N_CH);

    logic [ADDR_W-1:0] dest_s;
    logic              valid_dest_s;
    logic [N_CH-1:0]   full_s, empty_s, push_s, pop_s;
    logic [N_SLOT-1:0] full_ext_s;
    logic              drop_q, drop_d;

    // Address decode, sink-and-drop readiness and per-channel push/pop strobes.
    always_comb begin
        dest_s       = data_i[PKT_W-1 -: ADDR_W];
        valid_dest_s = ({1'b0, dest_s} < N_CH_L);
        full_ext_s   = N_SLOT'(full_s);
        if (valid_dest_s) begin
            ready_o = ~full_ext_s[dest_s];
        end else begin
            ready_o = 1'b1;
        end
        for (int c = 0; c < int'(N_CH); c++) begin
            push_s[c] = valid_i & ready_o & valid_dest_s & (dest_s == ADDR_W'(c));
            pop_s[c]  = ~empty_s[c] & ready_i[c];
        end
        drop_d = valid_i & ~valid_dest_s;
    end

    assign valid_o = ~empty_s;
    assign drop_o  = drop_q;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_chan
        router_chan_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push_s[g]),
            .data_i  (data_i[DATA_W-1:0]),
            .pop_i   (pop_s[g]),
            .full_o  (full_s[g]),
            .empty_o (empty_s[g]),
            .head_o  (data_o[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

`ifdef ROUTER_STATS_EN
    logic [N_CH-1:0][CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;

    // Saturating pop and drop counters.
    always_comb begin
        for (int c = 0; c < int'(N_CH); c++) begin
            if (pop_s[c]) begin
                pkt_cnt_d[c] = CNT_W'(sat_inc(64'(pkt_cnt_q[c]), CNT_W));
            end else begin
                pkt_cnt_d[c] = pkt_cnt_q[c];
            end
        end
        if (drop_d) begin
            drop_cnt_d = CNT_W'(sat_inc(64'(drop_cnt_q), CNT_W));
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_nch_voq.sv
// Self-checking bench for router_nch_voq (N_CH=3 so address 3 exercises the drop path).
// Statistics checks are compiled in when ROUTER_STATS_EN is defined.
module tb_router_nch_voq;

    localparam int N_CH  = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int PW    = AW + DW;
    localparam int CW    = 2;
    localparam int CMAX  = 3;

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic                    valid_i;
    logic [PW-1:0]           data_i;
    logic                    ready_o;
    logic                    drop_o;
    logic [N_CH-1:0]         valid_o;
    logic [N_CH-1:0][DW-1:0] data_o;
    logic [N_CH-1:0]         ready_i;
`ifdef ROUTER_STATS_EN
    logic [N_CH-1:0][CW-1:0] pkt_cnt_o;
    logic [CW-1:0]           drop_cnt_o;
`endif

    router_nch_voq #(
        .N_CH       (N_CH),
        .DATA_W     (DW),
`ifdef ROUTER_STATS_EN
        .CNT_W      (CW),
`endif
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .drop_o     (drop_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
`ifdef ROUTER_STATS_EN
        .pkt_cnt_o  (pkt_cnt_o),
        .drop_cnt_o (drop_cnt_o),
`endif
        .ready_i    (ready_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues per channel plus expected drop pulse and counters.
    logic [DW-1:0] mq [N_CH][$];
    logic          exp_drop = 1'b0;
    int            pkt_cnt [N_CH];
    int            drop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int addr, input int pay, input logic [N_CH-1:0] rdy);
        valid_i = v;
        data_i  = {AW'(addr), DW'(pay)};
        ready_i = rdy;
    endtask

    task automatic check_outputs();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("valid_o[%0d]", c), 32'(valid_o[c]), 32'(mq[c].size() > 0));
            chk($sformatf("data_o[%0d]", c), 32'(data_o[c]),
                (mq[c].size() > 0) ? 32'(mq[c][0]) : 32'd0);
`ifdef ROUTER_STATS_EN
            chk($sformatf("pkt_cnt_o[%0d]", c), 32'(pkt_cnt_o[c]), 32'(pkt_cnt[c]));
`endif
        end
        chk("drop_o", 32'(drop_o), 32'(exp_drop));
`ifdef ROUTER_STATS_EN
        chk("drop_cnt_o", 32'(drop_cnt_o), 32'(drop_cnt));
`endif
    endtask

    task automatic clear_model();
        for (int c = 0; c < N_CH; c++) begin
            mq[c].delete();
            pkt_cnt[c] = 0;
        end
        exp_drop = 1'b0;
        drop_cnt = 0;
    endtask

    // One clock: check ready_o, advance the model at the edge, check outputs on the falling edge.
    task automatic cycle();
        int dest;
        int pre [N_CH];
        #1;
        dest = int'(data_i[PW-1 -: AW]);
        chk("ready_o", 32'(ready_o), (dest >= N_CH) ? 32'd1 : 32'(mq[dest].size() < DEPTH));
        for (int c = 0; c < N_CH; c++) pre[c] = mq[c].size();
        @(posedge clk);
        for (int c = 0; c < N_CH; c++) begin
            if (pre[c] > 0 && ready_i[c]) begin
                void'(mq[c].pop_front());
                if (pkt_cnt[c] < CMAX) pkt_cnt[c]++;
            end
        end
        exp_drop = valid_i && (dest >= N_CH);
        if (exp_drop && drop_cnt < CMAX) drop_cnt++;
        if (valid_i && dest < N_CH) begin
            if (pre[dest] < DEPTH) mq[dest].push_back(data_i[DW-1:0]);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values();
        #1;
        chk("rst valid_o", 32'(valid_o), 32'd0);
        chk("rst data_o", 32'(data_o), 32'd0);
        chk("rst drop_o", 32'(drop_o), 32'd0);
        chk("rst ready_o", 32'(ready_o), 32'd1);
`ifdef ROUTER_STATS_EN
        chk("rst pkt_cnt_o", 32'(pkt_cnt_o), 32'd0);
        chk("rst drop_cnt_o", 32'(drop_cnt_o), 32'd0);
`endif
    endtask

    initial begin
        clear_model();
        rst_ni = 1'b0;
        drive(0, 0, 0, '0);
        repeat (2) @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst_ni = 1'b1;

        // Single packet to ch2 held, then released.
        drive(1, 2, 'hA5, 3'b000); cycle();
        drive(0, 0, 0, 3'b000);    cycle();
        drive(0, 0, 0, 3'b100);    cycle();
        cycle();

        // Fill ch1; ch2 still accepts traffic.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 'h10 + i, 3'b000); cycle();
        end
        drive(1, 1, 'h99, 3'b000); cycle();
        drive(1, 2, 'h3C, 3'b000); cycle();
        drive(0, 0, 0, 3'b111);
        repeat (6) cycle();

        // Full ch0 with concurrent pop: not ready that cycle, ready next.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 'h20 + i, 3'b000); cycle();
        end
        drive(1, 0, 'h77, 3'b001); cycle();
        drive(1, 0, 'h78, 3'b001); cycle();
        drive(0, 0, 0, 3'b001);
        repeat (5) cycle();

        // Non-full push+pop keeps order.
        drive(1, 0, 'h01, 3'b000); cycle();
        drive(1, 0, 'h02, 3'b001); cycle();
        drive(1, 0, 'h03, 3'b001); cycle();
        drive(0, 0, 0, 3'b001);
        repeat (3) cycle();

        // Out-of-range address: dropped, one-cycle pulse.
        drive(1, 3, 'h55, 3'b000); cycle();
        drive(0, 0, 0, 3'b000);    cycle();
        drive(1, 3, 'h66, 3'b000); cycle();
        drive(0, 0, 0, 3'b000);    cycle();

        // Five pops of ch0 to exercise counter saturation.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 'h40 + i, 3'b001); cycle();
        end
        drive(0, 0, 0, 3'b001);
        repeat (2) cycle();

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 'h80 + i, 3'b000); cycle();
        end
        drive(1, 3, 'h11, 3'b000); cycle();
        drive(0, 0, 0, 3'b000);
        rst_ni = 1'b0;
        clear_model();
        check_reset_values();
        @(negedge clk);
        rst_ni = 1'b1;

        repeat (400) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), N_CH'($urandom_range(0, 7)));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
